// File: rtl/ay_bus_pkg.sv
// Shared constants and types for the AY-3-8910 bus sequencer.
// Command codes are packed as {bdir, bc1}.
package ay_bus_pkg;

  localparam logic [1:0] CMD_INACT = 2'b00;
  localparam logic [1:0] CMD_LADDR = 2'b11;
  localparam logic [1:0] CMD_WRPSG = 2'b10;
  localparam logic [1:0] CMD_RDPSG = 2'b01;

  localparam logic [1:0] MODE_NOVO  = 2'd0;
  localparam logic [1:0] MODE_STAS1 = 2'd1;
  localparam logic [1:0] MODE_STAS2 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_READ,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_ADDR,
    DEC_WRITE,
    DEC_READ
  } dec_e;

  function automatic int tmax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ay_bus_seq_if.sv
// Parallel-port handshake bundle seen by the AY sequencer.
// The host side drives every line; the sequencer only listens.
interface ay_bus_seq_if;
  logic       sel;
  logic       strobe;
  logic       wrbt;
  logic       dout;
  logic [7:0] din;

  modport master (
    output sel, strobe, wrbt, dout, din
  );

  modport slave (
    input sel, strobe, wrbt, dout, din
  );
endinterface

// File: rtl/ay_port_sync.sv
// Two-flop synchroniser for the port control lines plus a
// strobe rising-edge detector producing a single event pulse.
module ay_port_sync (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic strobe,
  input  logic wrbt,
  input  logic dout,
  output logic evt,
  output logic sel_s,
  output logic wrbt_s,
  output logic dout_s
);

  // bit order: {sel, strobe, wrbt, dout}
  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;
  logic       stb_prev_q, stb_prev_d;

  // Next values of the synchroniser chain and edge history
  always_comb begin
    meta_d     = {sel, strobe, wrbt, dout};
    sync_d     = meta_q;
    stb_prev_d = sync_q[2];
  end

  // Synchroniser and edge-history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      stb_prev_q <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      stb_prev_q <= stb_prev_d;
    end
  end

  assign evt    = sync_q[2] & ~stb_prev_q;
  assign sel_s  = sync_q[3];
  assign wrbt_s = sync_q[1];
  assign dout_s = sync_q[0];

endmodule

// File: rtl/ay_bus_seq.sv
// Clocked AY-3-8910 bus sequencer for the BK-0011M parallel port:
// decodes port strobes and emits timed BDIR/BC1 cycles per chip.
module ay_bus_seq
  import ay_bus_pkg::*;
#(
  parameter int NCHIPS = 1,
  parameter int T_ADDR = 2,
  parameter int T_WR   = 3,
  parameter int T_RD   = 3,
  parameter int T_GAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  ay_bus_seq_if.slave       pif,
  input  logic [7:0]        da_in,
  output logic [7:0]        da_out,
  output logic              da_oe,
  output logic [NCHIPS-1:0] bdir,
  output logic [NCHIPS-1:0] bc1,
  output logic [1:0]        chip_sel,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int TMAX =
    tmax(tmax(T_ADDR, T_WR), tmax(T_RD, T_GAP));
  localparam int CW = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] LD_ADDR = CW'(T_ADDR - 1);
  localparam logic [CW-1:0] LD_WR   = CW'(T_WR - 1);
  localparam logic [CW-1:0] LD_RD   = CW'(T_RD - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(T_GAP - 1);

  // Lowest din that is a chip-select code rather than an address
  localparam logic [7:0] CS_MIN = 8'(255 - (NCHIPS - 1));

  logic evt, sel_s, wrbt_s, dout_s;

  ay_port_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .sel    (pif.sel),
    .strobe (pif.strobe),
    .wrbt   (pif.wrbt),
    .dout   (pif.dout),
    .evt    (evt),
    .sel_s  (sel_s),
    .wrbt_s (wrbt_s),
    .dout_s (dout_s)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic [1:0]    chip_q, chip_d;
  logic          an_q, an_d;
  logic [7:0]    rdd_q, rdd_d;
  logic          rdv_q, rdv_d;
  logic          ovr_q, ovr_d;

  dec_e dec;
  logic is_addr;
  logic is_cs;
  logic an_next;
  logic accept;
  logic drop;
  logic [1:0] cmd;

  assign accept = evt & sel_s & (state_q == ST_IDLE);
  assign drop   = evt & sel_s & (state_q != ST_IDLE);

  // Decode the synchronised port lines into a bus command
  always_comb begin
    dec     = DEC_NONE;
    is_addr = 1'b0;
    an_next = an_q;
    if (!dout_s) begin
      dec = DEC_READ;
      if (mode == MODE_STAS1) an_next = 1'b1;
    end else begin
      unique case (1'b1)
        (mode == MODE_STAS1): begin
          is_addr = an_q;
          an_next = ~an_q;
        end
        (mode == MODE_STAS2): is_addr = ~wrbt_s;
        default:              is_addr = wrbt_s;
      endcase
      dec = is_addr ? DEC_ADDR : DEC_WRITE;
    end
    is_cs = (NCHIPS > 1) && is_addr &&
            (pif.din >= CS_MIN);
  end

  // FSM state and dwell counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; counter reloads on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !is_cs) begin
          unique case (dec)
            DEC_ADDR: begin
              state_d = ST_ADDR;
              cnt_d   = LD_ADDR;
            end
            DEC_WRITE: begin
              state_d = ST_WRITE;
              cnt_d   = LD_WR;
            end
            DEC_READ: begin
              state_d = ST_READ;
              cnt_d   = LD_RD;
            end
            DEC_NONE: ;
          endcase
        end
      end
      ST_ADDR, ST_WRITE, ST_READ: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = LD_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus strobes and DA drive follow the current state
  always_comb begin
    cmd   = CMD_INACT;
    da_oe = 1'b0;
    unique case (state_q)
      ST_ADDR: begin
        cmd   = CMD_LADDR;
        da_oe = 1'b1;
      end
      ST_WRITE: begin
        cmd   = CMD_WRPSG;
        da_oe = 1'b1;
      end
      ST_READ: cmd = CMD_RDPSG;
      default: ;
    endcase
    bdir = '0;
    bc1  = '0;
    for (int i = 0; i < NCHIPS; i++) begin
      bdir[i] = cmd[1] & (chip_q == 2'(i));
      bc1[i]  = cmd[0] & (chip_q == 2'(i));
    end
  end

  // Datapath: latched data, chip select, Stas1 toggle, read-back
  always_comb begin
    din_d  = din_q;
    chip_d = chip_q;
    an_d   = an_q;
    rdd_d  = rdd_q;
    rdv_d  = 1'b0;
    ovr_d  = ovr_q | drop;
    if (accept) begin
      an_d = an_next;
      if (is_cs) chip_d = 2'(8'hFF - pif.din);
      else din_d = pif.din;
    end
    if (state_q == ST_READ && cnt_q == '0) begin
      rdd_d = da_in;
      rdv_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q  <= '0;
      chip_q <= '0;
      an_q   <= 1'b1;
      rdd_q  <= '0;
      rdv_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      din_q  <= din_d;
      chip_q <= chip_d;
      an_q   <= an_d;
      rdd_q  <= rdd_d;
      rdv_q  <= rdv_d;
      ovr_q  <= ovr_d;
    end
  end

  assign da_out   = din_q;
  assign chip_sel = chip_q;
  assign rd_data  = rdd_q;
  assign rd_valid = rdv_q;
  assign busy     = (state_q != ST_IDLE);
  assign overrun  = ovr_q;

endmodule
